axil_csr_bank: RTL and testbench

AXIL_CSR_BANK -- requirements
Module: axil_csr_bank

---
 rtl/axil_csr_pkg.sv | 52 +++++
 rtl/axil_csr_wr_fsm.sv | 102 ++++++++++
 rtl/axil_csr_bank.sv | 179 +++++++++++++++++
 tb/tb_axil_csr_bank.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_csr_pkg.sv
// Shared types for the AXI-Lite CSR bank: bus request/response structs, response codes
// and FSM state encodings. Struct fields are sized for the widest legal configuration.
package axil_csr_pkg;

    localparam int AXIL_ADDR_MAX = 32;
    localparam int AXIL_DATA_MAX = 64;
    localparam int AXIL_STRB_MAX = AXIL_DATA_MAX / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_AHELD = 2'd1,
        W_DHELD = 2'd2,
        W_RESP  = 2'd3
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic                     awvalid;
        logic [AXIL_ADDR_MAX-1:0] awaddr;
        logic                     wvalid;
        logic [AXIL_DATA_MAX-1:0] wdata;
        logic [AXIL_STRB_MAX-1:0] wstrb;
        logic                     bready;
        logic                     arvalid;
        logic [AXIL_ADDR_MAX-1:0] araddr;
        logic                     rready;
    } axil_req_t;

    typedef struct packed {
        logic                     awready;
        logic                     wready;
        logic                     bvalid;
        logic [1:0]               bresp;
        logic                     arready;
        logic                     rvalid;
        logic [AXIL_DATA_MAX-1:0] rdata;
        logic [1:0]               rresp;
    } axil_rsp_t;

    // Number of byte-offset address bits below the word index.
    function automatic int lsb_of(input int data_w);
        return (data_w == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/axil_csr_wr_fsm.sv
// AXI-Lite write-channel FSM: accepts AW and W in any order, emits a one-cycle
// commit strobe with index/data/strobes, then holds the B response until bready.
module axil_csr_wr_fsm
    import axil_csr_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int IDX_W  = ADDR_W - lsb_of(DATA_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                awvalid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                wvalid,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                bready,
    input  logic                commit_err,
    output logic                awready,
    output logic                wready,
    output logic                bvalid,
    output logic [1:0]          bresp,
    output logic                commit,
    output logic [IDX_W-1:0]    commit_idx,
    output logic [DATA_W-1:0]   commit_data,
    output logic [DATA_W/8-1:0] commit_strb,
    output wr_state_t           state
);

    localparam int LSB = lsb_of(DATA_W);

    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W/8-1:0] strb_q;
    logic [ADDR_W-1:0]   addr_sel;
    logic                aw_hs;
    logic                w_hs;
    logic                unused_lsb;

    // Whichever half arrived first is replayed from its holding register.
    always_comb begin
        aw_hs       = awvalid && awready;
        w_hs        = wvalid && wready;
        addr_sel    = (state == W_AHELD) ? addr_q : awaddr;
        commit_data = (state == W_DHELD) ? data_q : wdata;
        commit_strb = (state == W_DHELD) ? strb_q : wstrb;
        commit_idx  = addr_sel[ADDR_W-1:LSB];
        commit      = 1'b0;
        case (state)
            W_IDLE:  commit = aw_hs && w_hs;
            W_AHELD: commit = w_hs;
            W_DHELD: commit = aw_hs;
            default: commit = 1'b0;
        endcase
    end

    assign unused_lsb = ^addr_sel[LSB-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b1;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else if (commit) begin
            state   <= W_RESP;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= commit_err ? RESP_SLVERR : RESP_OKAY;
        end else begin
            case (state)
                W_IDLE: begin
                    if (aw_hs) begin
                        addr_q  <= awaddr;
                        awready <= 1'b0;
                        state   <= W_AHELD;
                    end else if (w_hs) begin
                        data_q <= wdata;
                        strb_q <= wstrb;
                        wready <= 1'b0;
                        state  <= W_DHELD;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        state   <= W_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axil_csr_bank.sv
// AXI-Lite register bank: NUM_CTRL read/write control registers followed by NUM_STATUS
// read-only status words. Defining AXIL_CSR_WSTRB_EN enables per-byte write strobes.
module axil_csr_bank
    import axil_csr_pkg::*;
#(
    parameter int                NUM_CTRL     = 8,
    parameter int                NUM_STATUS   = 8,
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 12,
    parameter int                CMD_IDX      = 0,
    parameter logic [DATA_W-1:0] CTRL_RST_VAL = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  axil_req_t                            axil_req,
    output axil_rsp_t                            axil_rsp,
    input  logic [NUM_STATUS-1:0][DATA_W-1:0]    status_i,
    output logic [NUM_CTRL-1:0][DATA_W-1:0]      ctrl_o,
    output logic [7:0]                           cmd_o,
    output logic                                 cmd_pulse_o
);

    localparam int LSB   = lsb_of(DATA_W);
    localparam int IDX_W = ADDR_W - LSB;

    logic [NUM_CTRL-1:0][DATA_W-1:0] ctrl_q;
    logic                            cmd_pulse_q;

    logic                awready;
    logic                wready;
    logic                bvalid;
    logic [1:0]          bresp;
    logic                commit;
    logic [IDX_W-1:0]    commit_idx;
    logic [DATA_W-1:0]   commit_data;
    logic [DATA_W/8-1:0] commit_strb;
    wr_state_t           wr_state;
    logic                wr_err;
    logic [NUM_CTRL-1:0] wr_hit;

    rd_state_t           rd_state;
    logic                arready;
    logic                rvalid;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          rresp;
    logic [IDX_W-1:0]    ar_idx;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_err;
    logic                unused_ok;

    axil_csr_wr_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_wr_fsm (
        .clk         (clk),
        .rst         (rst),
        .awvalid     (axil_req.awvalid),
        .awaddr      (axil_req.awaddr[ADDR_W-1:0]),
        .wvalid      (axil_req.wvalid),
        .wdata       (axil_req.wdata[DATA_W-1:0]),
        .wstrb       (axil_req.wstrb[DATA_W/8-1:0]),
        .bready      (axil_req.bready),
        .commit_err  (wr_err),
        .awready     (awready),
        .wready      (wready),
        .bvalid      (bvalid),
        .bresp       (bresp),
        .commit      (commit),
        .commit_idx  (commit_idx),
        .commit_data (commit_data),
        .commit_strb (commit_strb),
        .state       (wr_state)
    );

    // Only control indices are writable; status and unmapped indices answer SLVERR.
    always_comb begin
        wr_hit = '0;
        wr_err = 1'b1;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (commit_idx == IDX_W'(i)) begin
                wr_hit[i] = 1'b1;
                wr_err    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CTRL; i++) begin
                ctrl_q[i] <= CTRL_RST_VAL;
            end
            cmd_pulse_q <= 1'b0;
        end else begin
            cmd_pulse_q <= commit && wr_hit[CMD_IDX];
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (commit && wr_hit[i]) begin
`ifdef AXIL_CSR_WSTRB_EN
                    for (int b = 0; b < DATA_W/8; b++) begin
                        if (commit_strb[b]) begin
                            ctrl_q[i][8*b +: 8] <= commit_data[8*b +: 8];
                        end
                    end
`else
                    ctrl_q[i] <= commit_data;
`endif
                end
            end
        end
    end

    assign ar_idx = axil_req.araddr[ADDR_W-1:LSB];

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_data = ctrl_q[i];
                rd_err  = 1'b0;
            end
        end
        for (int j = 0; j < NUM_STATUS; j++) begin
            if (ar_idx == IDX_W'(NUM_CTRL + j)) begin
                rd_data = status_i[j];
                rd_err  = 1'b0;
            end
        end
    end

    // Read data is captured on the AR edge, so a same-edge commit is not yet visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            arready  <= 1'b1;
            rvalid   <= 1'b0;
            rdata_q  <= '0;
            rresp    <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (axil_req.arvalid) begin
                        rdata_q  <= rd_data;
                        rresp    <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        rvalid   <= 1'b1;
                        arready  <= 1'b0;
                        rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axil_req.rready) begin
                        rvalid   <= 1'b0;
                        arready  <= 1'b1;
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        axil_rsp         = '0;
        axil_rsp.awready = awready;
        axil_rsp.wready  = wready;
        axil_rsp.bvalid  = bvalid;
        axil_rsp.bresp   = bresp;
        axil_rsp.arready = arready;
        axil_rsp.rvalid  = rvalid;
        axil_rsp.rdata   = AXIL_DATA_MAX'(rdata_q);
        axil_rsp.rresp   = rresp;
    end

    assign ctrl_o      = ctrl_q;
    assign cmd_o       = ctrl_q[CMD_IDX][7:0];
    assign cmd_pulse_o = cmd_pulse_q;
    assign unused_ok   = ^{axil_req, commit_strb, wr_state};

endmodule

// File: tb/tb_axil_csr_bank.sv
// Directed and randomized bench for axil_csr_bank against a word-array reference model.
module tb_axil_csr_bank;
    import axil_csr_pkg::*;

    localparam int NUM_CTRL   = 8;
    localparam int NUM_STATUS = 8;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 12;
    localparam int CMD_IDX    = 0;
    localparam logic [DATA_W-1:0] RST_VAL = '0;

    logic                              clk = 1'b0;
    logic                              rst;
    axil_req_t                         req;
    axil_rsp_t                         rsp;
    logic [NUM_STATUS-1:0][DATA_W-1:0] status;
    logic [NUM_CTRL-1:0][DATA_W-1:0]   ctrl;
    logic [7:0]                        cmd;
    logic                              cmd_pulse;

    logic [DATA_W-1:0] model_ctrl [NUM_CTRL];
    logic [DATA_W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    axil_csr_bank #(
        .NUM_CTRL     (NUM_CTRL),
        .NUM_STATUS   (NUM_STATUS),
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .CMD_IDX      (CMD_IDX),
        .CTRL_RST_VAL (RST_VAL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axil_req    (req),
        .axil_rsp    (rsp),
        .status_i    (status),
        .ctrl_o      (ctrl),
        .cmd_o       (cmd),
        .cmd_pulse_o (cmd_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] apply_write(input logic [DATA_W-1:0] old,
                                                      input logic [DATA_W-1:0] data,
                                                      input logic [3:0] strb);
        logic [DATA_W-1:0] mask;
        mask = '1;
`ifdef AXIL_CSR_WSTRB_EN
        for (int b = 0; b < DATA_W/8; b++) mask[8*b +: 8] = {8{strb[b]}};
`endif
        return (old & ~mask) | (data & mask);
    endfunction

    task automatic check_all_ctrl(input string tag);
        for (int i = 0; i < NUM_CTRL; i++)
            check($sformatf("%s_ctrl%0d", tag, i), 64'(ctrl[i]), 64'(model_ctrl[i]));
        check({tag, "_cmd"}, 64'(cmd), 64'(model_ctrl[CMD_IDX][7:0]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bvalid"}, 64'(rsp.bvalid), 64'd0);
        check({tag, "_rvalid"}, 64'(rsp.rvalid), 64'd0);
        check({tag, "_awready"}, 64'(rsp.awready), 64'd1);
        check({tag, "_wready"}, 64'(rsp.wready), 64'd1);
        check({tag, "_arready"}, 64'(rsp.arready), 64'd1);
        check({tag, "_rdata"}, rsp.rdata, 64'd0);
        check({tag, "_pulse"}, 64'(cmd_pulse), 64'd0);
        check_all_ctrl(tag);
    endtask

    task automatic do_write(input int idx, input logic [DATA_W-1:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hit, w_hit;
        int c = 0;
        logic [1:0] exp_resp;
        exp_resp = (idx < NUM_CTRL) ? RESP_OKAY : RESP_SLVERR;
        if (idx < NUM_CTRL) model_ctrl[idx] = apply_write(model_ctrl[idx], data, strb);
        req.awaddr = 32'(idx * (DATA_W/8) + $urandom_range(0, DATA_W/8 - 1));
        req.wdata  = 64'(data);
        req.wstrb  = 8'(strb);
        while (!(aw_done && w_done) && c < 50) begin
            req.awvalid = !aw_done && (c >= aw_dly);
            req.wvalid  = !w_done && (c >= w_dly);
            aw_hit = req.awvalid && rsp.awready;
            w_hit  = req.wvalid && rsp.wready;
            @(posedge clk); #1;
            if (aw_hit) aw_done = 1;
            if (w_hit) w_done = 1;
            if (!(aw_done && w_done)) check("bvalid_early", 64'(rsp.bvalid), 64'd0);
            c++;
        end
        req.awvalid = 1'b0;
        req.wvalid  = 1'b0;
        check("wr_handshake", 64'(aw_done && w_done), 64'd1);
        check("bvalid_latency", 64'(rsp.bvalid), 64'd1);
        check("bresp", 64'(rsp.bresp), 64'(exp_resp));
        check("cmd_pulse", 64'(cmd_pulse), 64'(idx == CMD_IDX));
        check_all_ctrl("wr");
        for (int k = 0; k < b_dly; k++) begin
            @(posedge clk); #1;
            check("bvalid_hold", 64'(rsp.bvalid), 64'd1);
            check("bresp_hold", 64'(rsp.bresp), 64'(exp_resp));
            check("cmd_pulse_once", 64'(cmd_pulse), 64'd0);
        end
        req.bready = 1'b1;
        @(posedge clk); #1;
        req.bready = 1'b0;
        check("bvalid_clear", 64'(rsp.bvalid), 64'd0);
        check("cmd_pulse_end", 64'(cmd_pulse), 64'd0);
        check("awready_back", 64'(rsp.awready), 64'd1);
    endtask

    task automatic do_read(input int idx, input int r_dly);
        logic [DATA_W-1:0] exp_data;
        logic [1:0] exp_resp;
        if (idx < NUM_CTRL) begin
            exp_data = model_ctrl[idx];
            exp_resp = RESP_OKAY;
        end else if (idx < NUM_CTRL + NUM_STATUS) begin
            exp_data = status[idx - NUM_CTRL];
            exp_resp = RESP_OKAY;
        end else begin
            exp_data = '0;
            exp_resp = RESP_SLVERR;
        end
        exp_q.push_back(exp_data);
        req.araddr  = 32'(idx * (DATA_W/8) + $urandom_range(0, DATA_W/8 - 1));
        req.arvalid = 1'b1;
        check("arready_idle", 64'(rsp.arready), 64'd1);
        @(posedge clk); #1;
        req.arvalid = 1'b0;
        exp_data = exp_q.pop_front();
        check("rvalid_latency", 64'(rsp.rvalid), 64'd1);
        check("rdata", rsp.rdata, 64'(exp_data));
        check("rresp", 64'(rsp.rresp), 64'(exp_resp));
        for (int k = 0; k < r_dly; k++) begin
            @(posedge clk); #1;
            check("rvalid_hold", 64'(rsp.rvalid), 64'd1);
            check("rdata_hold", rsp.rdata, 64'(exp_data));
            check("arready_busy", 64'(rsp.arready), 64'd0);
        end
        req.rready = 1'b1;
        @(posedge clk); #1;
        req.rready = 1'b0;
        check("rvalid_clear", 64'(rsp.rvalid), 64'd0);
        check("arready_back", 64'(rsp.arready), 64'd1);
    endtask

    initial begin
        logic [DATA_W-1:0] pre, nxt;
        int idx, op;
        rst = 1'b1;
        req = '0;
        for (int j = 0; j < NUM_STATUS; j++) status[j] = $urandom;
        for (int i = 0; i < NUM_CTRL; i++) model_ctrl[i] = RST_VAL;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        rst = 1'b0;
        @(posedge clk); #1;

        // Same-cycle AW/W to index 2.
        do_write(2, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
        check("idx2_value", 64'(ctrl[2]), 64'hA5A5A5A5);

        // W three cycles ahead of AW to the command index.
        do_write(0, 32'h00000042, 4'hF, 3, 0, 0);
        check("cmd_value", 64'(cmd), 64'h42);

        // AW ahead of W, with a delayed bready.
        do_write(5, 32'hDEADBEEF, 4'hF, 0, 2, 3);

        // Status read with rready held off.
        status[1] = 32'h00001234;
        do_read(NUM_CTRL + 1, 5);

        // Status write and unmapped read are rejected.
        do_write(9, 32'hFFFFFFFF, 4'hF, 0, 0, 1);
        do_read(20, 0);

        // Read and write commit on the same edge: read sees the old value.
        pre = model_ctrl[3];
        nxt = 32'hC0FFEE01;
        req.awaddr  = 32'(3 * 4);
        req.wdata   = 64'(nxt);
        req.wstrb   = 8'hFF;
        req.araddr  = 32'(3 * 4);
        req.awvalid = 1'b1;
        req.wvalid  = 1'b1;
        req.arvalid = 1'b1;
        @(posedge clk); #1;
        req.awvalid = 1'b0;
        req.wvalid  = 1'b0;
        req.arvalid = 1'b0;
        model_ctrl[3] = nxt;
        check("conc_rdata_old", rsp.rdata, 64'(pre));
        check("conc_ctrl_new", 64'(ctrl[3]), 64'(nxt));
        check("conc_bvalid", 64'(rsp.bvalid), 64'd1);
        check("conc_rvalid", 64'(rsp.rvalid), 64'd1);
        req.bready = 1'b1;
        req.rready = 1'b1;
        @(posedge clk); #1;
        req.bready = 1'b0;
        req.rready = 1'b0;
        check("conc_done", 64'({rsp.bvalid, rsp.rvalid}), 64'd0);

        // Reset while a write response is pending.
        req.awaddr  = 32'(6 * 4);
        req.wdata   = 64'(32'h11223344);
        req.awvalid = 1'b1;
        req.wvalid  = 1'b1;
        @(posedge clk); #1;
        req.awvalid = 1'b0;
        req.wvalid  = 1'b0;
        check("pend_bvalid", 64'(rsp.bvalid), 64'd1);
        rst = 1'b1;
        #2;
        for (int i = 0; i < NUM_CTRL; i++) model_ctrl[i] = RST_VAL;
        check_reset_outputs("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_no_resp", 64'(rsp.bvalid), 64'd0);
        do_write(4, 32'h0BADF00D, 4'hF, 1, 0, 0);

`ifdef AXIL_CSR_WSTRB_EN
        do_write(1, 32'hFFFFFFFF, 4'b0010, 0, 0, 0);
        check("wstrb_lane1", 64'(ctrl[1]), 64'h0000FF00);
        do_write(CMD_IDX, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);
`endif

        // Randomized mix of reads and writes.
        for (int n = 0; n < 60; n++) begin
            for (int j = 0; j < NUM_STATUS; j++) status[j] = $urandom;
            op  = $urandom_range(0, 1);
            idx = $urandom_range(0, NUM_CTRL + NUM_STATUS + 3);
            if (op == 0)
                do_write(idx, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(idx, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
